// File: rtl/spree_mem_arbiter.sv
// Round-robin arbiter sharing one multi-cycle memory/device port between NREQ
// pipeline requesters, with one-FF-stall semantics on each requester.
module spree_mem_arbiter #(
    parameter int unsigned NREQ  = 2,
    parameter int unsigned ADDRW = 32,
    parameter int unsigned DATAW = 32
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ-1:0]       we,
    input  logic [NREQ*ADDRW-1:0] addr,
    input  logic [NREQ*DATAW-1:0] wdata,
    output logic [NREQ-1:0]       stalled,
    output logic [NREQ-1:0]       grant,
    output logic [DATAW-1:0]      rdata,
    output logic                  dev_en,
    output logic                  dev_we,
    output logic [ADDRW-1:0]      dev_addr,
    output logic [DATAW-1:0]      dev_wdata,
    input  logic                  dev_wait,
    input  logic [DATAW-1:0]      dev_rdata
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t          state, state_nxt;
    logic [IW-1:0]   owner, last, win;
    logic            cap_we;
    logic [ADDRW-1:0] cap_addr;
    logic [DATAW-1:0] cap_wdata;
    logic            take, done;

    logic [ADDRW-1:0] addr_a  [NREQ];
    logic [DATAW-1:0] wdata_a [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign addr_a[i]  = addr[i*ADDRW +: ADDRW];
        assign wdata_a[i] = wdata[i*DATAW +: DATAW];
    end

    // Rotating priority search starting just after the last completed owner.
    always_comb begin : pick
        logic          found;
        logic [IW-1:0] cand;
        int unsigned   idx;
        win   = '0;
        found = 1'b0;
        cand  = '0;
        idx   = 0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx  = (32'(last) + k) % NREQ;
            cand = IW'(idx);
            if (!found && req[cand]) begin
                win   = cand;
                found = 1'b1;
            end
        end
    end

    // Outputs are gated by resetn so a held request cannot look granted during reset.
    always_comb begin
        state_nxt = state;
        take      = 1'b0;
        done      = 1'b0;
        stalled   = '0;
        grant     = '0;
        dev_en    = 1'b0;
        dev_we    = 1'b0;
        dev_addr  = '0;
        dev_wdata = '0;
        case (state)
            IDLE: begin
                if (resetn && (|req)) begin
                    take       = 1'b1;
                    grant[win] = 1'b1;
                    dev_en     = 1'b1;
                    dev_we     = we[win];
                    dev_addr   = addr_a[win];
                    dev_wdata  = wdata_a[win];
                    stalled    = req;
                    state_nxt  = BUSY;
                end
            end
            BUSY: begin
                grant[owner] = 1'b1;
                dev_en       = 1'b1;
                dev_we       = cap_we;
                dev_addr     = cap_addr;
                dev_wdata    = cap_wdata;
                stalled      = req;
                if (!dev_wait) begin
                    done           = 1'b1;
                    stalled[owner] = 1'b0;
                    state_nxt      = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign rdata = dev_rdata;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            owner     <= '0;
            last      <= IW'(NREQ - 1);
            cap_we    <= 1'b0;
            cap_addr  <= '0;
            cap_wdata <= '0;
        end else begin
            state <= state_nxt;
            if (take) begin
                owner     <= win;
                cap_we    <= we[win];
                cap_addr  <= addr_a[win];
                cap_wdata <= wdata_a[win];
            end
            if (done) begin
                last <= owner;
            end
        end
    end

endmodule

// File: tb/tb_spree_mem_arbiter.sv
// Scoreboard bench for spree_mem_arbiter: a transaction-level model pushes the
// expected per-cycle outputs and a negedge monitor pops and compares them.
module tb_spree_mem_arbiter;

    localparam int NREQ = 3;
    localparam int AW   = 32;
    localparam int DW   = 32;

    logic                 clk;
    logic                 resetn;
    logic [NREQ-1:0]      req;
    logic [NREQ-1:0]      we;
    logic [NREQ*AW-1:0]   addr;
    logic [NREQ*DW-1:0]   wdata;
    logic [NREQ-1:0]      stalled;
    logic [NREQ-1:0]      grant;
    logic [DW-1:0]        rdata;
    logic                 dev_en;
    logic                 dev_we;
    logic [AW-1:0]        dev_addr;
    logic [DW-1:0]        dev_wdata;
    logic                 dev_wait;
    logic [DW-1:0]        dev_rdata;

    spree_mem_arbiter #(.NREQ(NREQ), .ADDRW(AW), .DATAW(DW)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .req       (req),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
        .stalled   (stalled),
        .grant     (grant),
        .rdata     (rdata),
        .dev_en    (dev_en),
        .dev_we    (dev_we),
        .dev_addr  (dev_addr),
        .dev_wdata (dev_wdata),
        .dev_wait  (dev_wait),
        .dev_rdata (dev_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [NREQ-1:0] stalled;
        logic [NREQ-1:0] grant;
        logic            dev_en;
        logic            dev_we;
        logic [AW-1:0]   dev_addr;
        logic [DW-1:0]   dev_wdata;
        logic [DW-1:0]   rdata;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    // Transaction-level reference: who owns the port and what it asked for.
    bit          m_busy;
    int          m_owner;
    int          m_last;
    logic        m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            tests++;
            if (stalled !== mon_e.stalled || grant !== mon_e.grant ||
                dev_en !== mon_e.dev_en || dev_we !== mon_e.dev_we ||
                dev_addr !== mon_e.dev_addr || dev_wdata !== mon_e.dev_wdata ||
                rdata !== mon_e.rdata) begin
                fails++;
                $display("FAIL cycle%0d: got stl=%b gnt=%b en=%b we=%b a=%h wd=%h rd=%h, expected stl=%b gnt=%b en=%b we=%b a=%h wd=%h rd=%h",
                         cyc, stalled, grant, dev_en, dev_we, dev_addr, dev_wdata, rdata,
                         mon_e.stalled, mon_e.grant, mon_e.dev_en, mon_e.dev_we,
                         mon_e.dev_addr, mon_e.dev_wdata, mon_e.rdata);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    task automatic model_reset();
        m_busy  = 1'b0;
        m_owner = 0;
        m_last  = NREQ - 1;
        m_we    = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
    endtask

    function automatic int pick();
        for (int k = 1; k <= NREQ; k++) begin
            int i;
            i = (m_last + k) % NREQ;
            if (req[i]) return i;
        end
        return -1;
    endfunction

    // Predict this cycle's outputs from the current inputs, then advance the model.
    task automatic model_step();
        exp_t e;
        int   w;
        e.stalled   = '0;
        e.grant     = '0;
        e.dev_en    = 1'b0;
        e.dev_we    = 1'b0;
        e.dev_addr  = '0;
        e.dev_wdata = '0;
        e.rdata     = dev_rdata;
        if (!m_busy) begin
            w = pick();
            if (w >= 0) begin
                e.grant[w]  = 1'b1;
                e.dev_en    = 1'b1;
                e.dev_we    = we[w];
                e.dev_addr  = addr[w*AW +: AW];
                e.dev_wdata = wdata[w*DW +: DW];
                e.stalled   = req;
                m_busy  = 1'b1;
                m_owner = w;
                m_we    = we[w];
                m_addr  = addr[w*AW +: AW];
                m_wdata = wdata[w*DW +: DW];
            end
        end else begin
            e.grant[m_owner] = 1'b1;
            e.dev_en    = 1'b1;
            e.dev_we    = m_we;
            e.dev_addr  = m_addr;
            e.dev_wdata = m_wdata;
            e.stalled   = req;
            if (!dev_wait) begin
                e.stalled[m_owner] = 1'b0;
                m_last = m_owner;
                m_busy = 1'b0;
            end
        end
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 4 && m_busy; i++) begin
            req      = '0;
            dev_wait = 1'b0;
            model_step();
            tick();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int gexp [4];
        gexp = '{1, 2, 4, 1};
        resetn    = 1'b0;
        req       = '0;
        we        = '0;
        addr      = '0;
        wdata     = '0;
        dev_wait  = 1'b0;
        dev_rdata = 32'h1234_5678;
        model_reset();

        // Outputs while held in reset.
        #12;
        check("rst_stalled",  32'(stalled),   0);
        check("rst_grant",    32'(grant),     0);
        check("rst_dev_en",   32'(dev_en),    0);
        check("rst_dev_we",   32'(dev_we),    0);
        check("rst_dev_addr", dev_addr,       0);
        check("rst_wdata",    dev_wdata,      0);
        check("rst_rdata",    rdata,          32'h1234_5678);
        tick();
        resetn = 1'b1;

        // Single read by requester 0.
        req = 3'b001; we = '0; addr[0 +: AW] = 32'h100; dev_rdata = 32'hCAFE;
        model_step();
        #1;
        check("rd_c0_stalled", 32'(stalled), 1);
        check("rd_c0_dev_en",  32'(dev_en),  1);
        check("rd_c0_addr",    dev_addr,     32'h100);
        tick();
        model_step();
        #1;
        check("rd_c1_stalled", 32'(stalled), 0);
        check("rd_c1_rdata",   rdata,        32'hCAFE);
        tick();
        req = '0;
        model_step();
        #1;
        check("rd_c2_dev_en",  32'(dev_en),  0);
        tick();

        // Two requesters held: alternating two-cycle tenures.
        req = 3'b011; addr[AW +: AW] = 32'h204;
        for (int i = 0; i < 12; i++) begin
            dev_rdata = $urandom;
            model_step();
            tick();
        end
        drain();

        // Write through a device with three wait cycles.
        req = 3'b010; we = 3'b010; wdata[DW +: DW] = 32'h55; addr[AW +: AW] = 32'h44;
        for (int i = 0; i < 5; i++) begin
            dev_wait = (i < 4);
            model_step();
            #1;
            check("mc_stalled1", 32'(stalled[1]), (i < 4) ? 1 : 0);
            check("mc_wdata",    dev_wdata,       32'h55);
            check("mc_we",       32'(dev_we),     1);
            tick();
            wdata[DW +: DW] = 32'h99;
        end
        req = '0; we = '0;
        drain();

        // Owner 0 squashes while the device is busy; requester 1 is pending.
        req = 3'b001; addr[0 +: AW] = 32'h200; dev_wait = 1'b1;
        m_last = 2;
        model_step();
        tick();
        req = 3'b010; addr[0 +: AW] = 32'h300;
        model_step();
        #1;
        check("sq_addr",    dev_addr,     32'h200);
        check("sq_stalled", 32'(stalled), 2);
        tick();
        dev_wait = 1'b0;
        model_step();
        tick();
        model_step();
        #1;
        check("sq_next_grant", 32'(grant), 2);
        tick();
        drain();

        // Asynchronous reset in the middle of a busy transaction.
        req = 3'b111; dev_wait = 1'b1;
        model_step();
        tick();
        model_step();
        tick();
        #1;
        resetn = 1'b0;
        #1;
        check("arst_dev_en",  32'(dev_en),  0);
        check("arst_grant",   32'(grant),   0);
        check("arst_stalled", 32'(stalled), 0);
        model_reset();
        tick();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;

        // Three requesters held: grant order 0,1,2,0.
        dev_wait = 1'b0;
        for (int i = 0; i < 7; i++) begin
            model_step();
            #1;
            if (i % 2 == 0) check("rr3_grant", 32'(grant), 32'(gexp[i/2]));
            tick();
        end
        drain();

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            req       = NREQ'($urandom_range(0, 7));
            we        = NREQ'($urandom_range(0, 7));
            for (int j = 0; j < NREQ; j++) begin
                addr[j*AW +: AW]  = $urandom;
                wdata[j*DW +: DW] = $urandom;
            end
            dev_wait  = ($urandom_range(0, 2) == 0);
            dev_rdata = $urandom;
            model_step();
            tick();
        end
        drain();
        req = '0;
        tick();
        tick();
        check("queue_empty", 32'(exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/spree_mem_arbiter.md
Name: spree_mem_arbiter

Overview:
- Shares one multi-cycle memory/device port between NREQ pipeline requesters, e.g. instruction fetch, data access and coprocessor.
- Round-robin arbitration with a two-state FSM.
- Each requester gets a per-port `stalled` signal with one-FF-stall semantics: always stalled in the first cycle of a request, then stalled while the device asserts wait.
- Sits between the pipeline stages and the single-ported memory/bus interface.

Parameters:
- NREQ, 2, number of requesters (2..8).
- ADDRW, 32, address width.
- DATAW, 32, data width.

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- req  in  NREQ  per-requester access request, level.
- we  in  NREQ  per-requester write enable (1 = write).
- addr  in  NREQ*ADDRW  flattened addresses; requester i occupies bits [i*ADDRW +: ADDRW].
- wdata  in  NREQ*DATAW  flattened write data, same packing.
- stalled  out  NREQ  per-requester stall to the pipeline.
- grant  out  NREQ  one-hot current owner; all zero when nobody owns the port.
- rdata  out  DATAW  read data, broadcast; valid in the owner's completion cycle.
- dev_en  out  1  device access enable.
- dev_we  out  1  device write enable.
- dev_addr  out  ADDRW  device address.
- dev_wdata  out  DATAW  device write data.
- dev_wait  in  1  device busy; don't-care in the grant cycle.
- dev_rdata  in  DATAW  device read data.

Behaviour:
- Clock and reset: one clock, clk. resetn is asynchronous and active-low. All flops clear immediately on resetn=0.
- Reset values: state=IDLE, owner=0, last=NREQ-1 (requester 0 therefore wins first), captured we/addr/wdata=0.
- Combinational outputs under reset with req=0: stalled=0, grant=0, dev_en=0, dev_we=0, dev_addr=0, dev_wdata=0, rdata=dev_rdata.
- Winner selection: the winner is the first i with req[i]=1, searching last+1, last+2, … modulo NREQ.
- IDLE, some req set:
  - Grant cycle. grant=onehot(winner) and dev_en=1.
  - dev_we/dev_addr/dev_wdata are driven combinationally from the winner's inputs.
  - stalled = req (every requester is stalled, including the winner).
  - Capture winner, we, addr and wdata into registers; next state is BUSY.
- IDLE, no req: dev_en=0, grant=0, stalled=0.
- BUSY:
  - dev_en=1. dev_we/addr/wdata come from the captured registers, so they stay stable even if requester inputs change. grant=onehot(owner).
  - dev_wait=1: stalled = req (all requesters stay stalled); remain in BUSY.
  - dev_wait=0 (completion): stalled[owner]=0, other requesters stalled = req; rdata=dev_rdata; last<=owner; next state IDLE.
- Latency: minimum 2 cycles from req to unstall (grant cycle + completion cycle). A device with k wait cycles gives 2+k.
- Back-to-back: the cycle after completion is IDLE and can grant again. A requester that re-asserts immediately competes under round-robin. Gap between accesses is 0 idle cycles.
- Owner drops req in BUSY (squash): the device transaction still runs to dev_wait=0 using the captured values. stalled[owner]=0 because req is low. last is updated normally.
- Non-owner req toggling: it only affects that requester's stalled bit; there is no pre-emption.
- Reset mid-BUSY: immediately IDLE with dev_en=0. The in-flight transaction is abandoned; the device is reset by the same resetn.
- Widths: no arithmetic. The round-robin index wraps modulo NREQ; NREQ need not be a power of 2.

Test Plan:
- Single read: after reset, req=01, we=0, addr0=0x100, dev_wait=0, dev_rdata=0xCAFE -> cycle 0 stalled=01, dev_en=1, dev_addr=0x100; cycle 1 stalled=00, rdata=0xCAFE; cycle 2 dev_en=0 once req drops.
- Simultaneous requests: req=11 held, dev_wait=0 -> grants 01,01,10,10,01,… (2-cycle tenures alternating); each requester unstalls once per 4 cycles; the losing side stays stalled=1 throughout.
- Multi-cycle device: req=10, we=1, wdata1=0x55, dev_wait=1 for 3 cycles after grant -> stalled[1]=1 for 4 cycles, dev_we=1 and dev_wdata=0x55 held throughout, unstall in cycle 4.
- Squash: owner 0 drops req after grant while dev_wait=1 -> dev_addr unchanged until dev_wait=0, stalled[0]=0 immediately, then IDLE; requester 1 granted next if pending.
- Async reset mid-BUSY: assert resetn=0 between clock edges -> dev_en, grant and stalled go to 0 without waiting for an edge; after release, requester 0 has priority.
- NREQ=3, req=111 held -> grant order 0,1,2,0 with no requester skipped.
